video_scanout: RTL

//   Read-side video timing engine for the 640x480 1-bpp frame buffer.

---
 rtl/video_timing_pkg.sv | 39 +++
 rtl/video_scanout_if.sv | 31 +++
 rtl/sig_delay.sv | 35 +++
 rtl/video_scanout.sv | 131 +++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_pkg
//  Description : Default 640x480@60 raster timing and shared scanout types.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Frame buffer geometry is tied to the scanout active area.
    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;

    localparam int CNT_W = 12;

    typedef struct packed {
        logic fs;
        logic de;
        logic vs;
        logic hs;
    } timing_bits_t;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_scanout_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_scanout_if
//  Description : Frame buffer read port plus video output bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_scanout_if;
    import video_timing_pkg::*;

    logic [CNT_W-1:0] xpos;
    logic [CNT_W-1:0] ypos;
    logic             color;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [23:0]      rgb;
    logic             vblank;
    logic             frame_start;

    modport master (
        output xpos, ypos, hsync, vsync, de, rgb, vblank, frame_start,
        input  color
    );

    modport slave (
        input  xpos, ypos, hsync, vsync, de, rgb, vblank, frame_start,
        output color
    );

endinterface
`default_nettype wire

// File: rtl/sig_delay.sv
`default_nettype none
// ============================================================================
//  Module      : sig_delay
//  Description : Reset-clearable WIDTH x DEPTH shift register (DEPTH >= 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module sig_delay #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : video_scanout
//  Description : Raster timing engine driving frame buffer reads and DVI video.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_scanout #(
    parameter int          H_ACTIVE   = video_timing_pkg::H_ACTIVE,
    parameter int          H_FP       = video_timing_pkg::H_FP,
    parameter int          H_SYNC     = video_timing_pkg::H_SYNC,
    parameter int          H_BP       = video_timing_pkg::H_BP,
    parameter int          V_ACTIVE   = video_timing_pkg::V_ACTIVE,
    parameter int          V_FP       = video_timing_pkg::V_FP,
    parameter int          V_SYNC     = video_timing_pkg::V_SYNC,
    parameter int          V_BP       = video_timing_pkg::V_BP,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int          FB_LATENCY = 1,
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    video_scanout_if.master   vid
);
    import video_timing_pkg::*;

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_act    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_act    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_hs_start = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_vs_start = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic [CNT_W-1:0] r_xpos;
    logic [CNT_W-1:0] r_ypos;
    logic             r_vblank;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic [CNT_W-1:0] w_vcnt_nxt;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [23:0]      r_rgb;
    logic             r_fs;

    timing_bits_t     w_raw;
    timing_bits_t     w_dly;
    logic [3:0]       w_dly_bits;

    always_comb begin
        w_hcnt_nxt = r_hcnt + 1'b1;
        w_vcnt_nxt = r_vcnt;
        if (r_hcnt == c_h_last) begin
            w_hcnt_nxt = '0;
            w_vcnt_nxt = (r_vcnt == c_v_last) ? '0 : r_vcnt + 1'b1;
        end
    end

    // Coordinates are derived from the next count so they change in the same
    // cycle as the counters; the frame buffer latency then lines up with the
    // raw timing delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt   <= '0;
            r_vcnt   <= '0;
            r_xpos   <= '0;
            r_ypos   <= '0;
            r_vblank <= 1'b0;
        end else begin
            r_hcnt   <= w_hcnt_nxt;
            r_vcnt   <= w_vcnt_nxt;
            r_xpos   <= (w_hcnt_nxt < c_h_act) ? w_hcnt_nxt : '0;
            r_ypos   <= (w_vcnt_nxt < c_v_act) ? w_vcnt_nxt : '0;
            r_vblank <= (w_vcnt_nxt >= c_v_act);
        end
    end

    always_comb begin
        w_raw.hs = (r_hcnt >= c_hs_start) && (r_hcnt < c_hs_end);
        w_raw.vs = (r_vcnt >= c_vs_start) && (r_vcnt < c_vs_end);
        w_raw.de = (r_hcnt < c_h_act) && (r_vcnt < c_v_act);
        w_raw.fs = (r_hcnt == '0) && (r_vcnt == '0);
    end

    sig_delay #(
        .WIDTH (4),
        .DEPTH (FB_LATENCY)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .i_d (w_raw),
        .o_q (w_dly_bits)
    );

    assign w_dly = timing_bits_t'(w_dly_bits);

    // Pixel colour for the delayed position is on vid.color in this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_de    <= 1'b0;
            r_rgb   <= '0;
            r_fs    <= 1'b0;
        end else begin
            r_hsync <= sync_level(w_dly.hs, SYNC_POL);
            r_vsync <= sync_level(w_dly.vs, SYNC_POL);
            r_de    <= w_dly.de;
            r_rgb   <= w_dly.de ? (vid.color ? FG_COLOR : BG_COLOR) : 24'h0;
            r_fs    <= w_dly.fs;
        end
    end

    assign vid.xpos        = r_xpos;
    assign vid.ypos        = r_ypos;
    assign vid.hsync       = r_hsync;
    assign vid.vsync       = r_vsync;
    assign vid.de          = r_de;
    assign vid.rgb         = r_rgb;
    assign vid.vblank      = r_vblank;
    assign vid.frame_start = r_fs;

endmodule
`default_nettype wire
